// File: rtl/risc_pkg.sv
// Shared processor constants and the fetch state encoding used by fetch and hazard logic.
package risc_pkg;

    localparam int unsigned IMEM_DEPTH = 32;
    localparam int unsigned RESET_PC   = 0;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned ADDR_W     = 16;

    typedef enum logic [1:0] {
        FETCH_FILL = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, drives the synchronous-read instruction memory and
// hands instructions to decode over a valid/stall handshake.
module instruction_fetch
    import risc_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = risc_pkg::IMEM_DEPTH,
    parameter int unsigned RESET_PC   = risc_pkg::RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [ADDR_W-1:0]    branch_target,
    output logic [ADDR_W-1:0]    imem_address,
    input  logic [INSTR_W-1:0]   imem_instruction,
    output logic [INSTR_W-1:0]   instr,
    output logic [ADDR_W-1:0]    instr_pc,
    output logic                 instr_valid
);

    localparam int unsigned PC_W = $clog2(IMEM_DEPTH);

    fetch_state_e         r_state;
    logic [PC_W-1:0]      r_fetch_pc;
    logic [PC_W-1:0]      r_req_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic [PC_W-1:0]      r_instr_pc;
    logic                 r_valid;

    fetch_state_e         w_state_nxt;
    logic [PC_W-1:0]      w_fetch_pc_nxt;
    logic [PC_W-1:0]      w_req_pc_nxt;
    logic [INSTR_W-1:0]   w_instr_nxt;
    logic [PC_W-1:0]      w_instr_pc_nxt;
    logic                 w_valid_nxt;
    logic [PC_W-1:0]      w_fetch_pc_inc;
    logic [PC_W-1:0]      w_target;

    // Increment wraps naturally at PC_W bits; target keeps only the in-range word bits.
    assign w_fetch_pc_inc = r_fetch_pc + PC_W'(1);
    assign w_target       = PC_W'(branch_target & ADDR_W'(IMEM_DEPTH - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_pc_nxt   = r_req_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        if (branch_taken) begin
            w_fetch_pc_nxt = w_target;
            w_valid_nxt    = 1'b0;
            w_state_nxt    = FETCH_FILL;
        end else begin
            case (r_state)
                FETCH_FILL: begin
                    w_req_pc_nxt   = r_fetch_pc;
                    w_fetch_pc_nxt = w_fetch_pc_inc;
                    w_state_nxt    = FETCH_RUN;
                end
                FETCH_RUN: begin
                    // A stalled valid instruction is held; the in-flight read is dropped and re-fetched later.
                    if (stall && r_valid) begin
                        w_fetch_pc_nxt = r_instr_pc + PC_W'(1);
                        w_state_nxt    = FETCH_HOLD;
                    end else begin
                        w_instr_nxt    = imem_instruction;
                        w_instr_pc_nxt = r_req_pc;
                        w_valid_nxt    = 1'b1;
                        w_req_pc_nxt   = r_fetch_pc;
                        w_fetch_pc_nxt = w_fetch_pc_inc;
                    end
                end
                FETCH_HOLD: begin
                    if (!stall) begin
                        w_valid_nxt    = 1'b0;
                        w_req_pc_nxt   = r_fetch_pc;
                        w_fetch_pc_nxt = w_fetch_pc_inc;
                        w_state_nxt    = FETCH_RUN;
                    end
                end
                default: begin
                    w_state_nxt = FETCH_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FETCH_FILL;
            r_fetch_pc <= PC_W'(RESET_PC);
            r_req_pc   <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign imem_address = ADDR_W'(r_fetch_pc);
    assign instr        = r_instr;
    assign instr_pc     = ADDR_W'(r_instr_pc);
    assign instr_valid  = r_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// traffic compared against a transaction-level model of the delivered stream.
module tb_instruction_fetch;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned RST_PC = 0;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_address;
    logic [15:0] imem_instruction;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;

    logic [15:0] mem [DEPTH];

    int checks;
    int failures;

    // Model: what decode should see, expressed as delivered stream + pending bubbles.
    bit          m_valid;
    int          m_pc;
    logic [15:0] m_instr;
    int          m_next;
    int          m_wait;
    bit          m_stalled;

    instruction_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_valid      (instr_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_instruction <= mem[5'(imem_address % 16'd32)];

    task automatic model_edge();
        if (reset) begin
            m_valid = 0; m_pc = 0; m_instr = '0;
            m_next = RST_PC; m_wait = 1; m_stalled = 0;
        end else if (branch_taken) begin
            m_valid = 0; m_next = int'(branch_target) % DEPTH; m_wait = 1; m_stalled = 0;
        end else if (m_valid && stall) begin
            m_stalled = 1;
        end else if (m_stalled) begin
            m_valid = 0; m_next = (m_pc + 1) % DEPTH; m_wait = 0; m_stalled = 0;
        end else if (m_wait > 0) begin
            m_wait--; m_valid = 0;
        end else begin
            m_valid = 1; m_pc = m_next; m_instr = mem[m_next];
            m_next = (m_next + 1) % DEPTH;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; branch_taken = 0; branch_target = '0;
        step(); step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", instr_valid); end
        checks++; if (instr !== 16'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0000", instr); end
        checks++; if (instr_pc !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0000", instr_pc); end
        checks++; if (imem_address !== 16'(RST_PC)) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_address, 16'(RST_PC)); end
        reset = 0;
    endtask

    task automatic test_startup();
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL start_fill got=%0h exp=0", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(i) || instr !== 16'(16'h1000 + i)) begin
                failures++;
                $display("FAIL start_seq%0d got v=%0h pc=%h i=%h exp v=1 pc=%h i=%h",
                         i, instr_valid, instr_pc, instr, 16'(i), 16'(16'h1000 + i));
            end
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        while (!(instr_valid && instr_pc == 16'd31) && n < 60) begin step(); n++; end
        checks++; if (instr !== 16'h101F || instr_valid !== 1'b1) begin failures++; $display("FAIL wrap_31 got v=%0h i=%h exp v=1 i=101f", instr_valid, instr); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0 || instr !== 16'h1000) begin
            failures++; $display("FAIL wrap_0 got v=%0h pc=%h i=%h exp v=1 pc=0000 i=1000", instr_valid, instr_pc, instr); end
    endtask

    task automatic run_to_pc(input int pc, input string name);
        int n = 0;
        while (!(instr_valid && instr_pc == 16'(pc)) && n < 60) begin step(); n++; end
        checks++; if (!(instr_valid && instr_pc == 16'(pc))) begin failures++; $display("FAIL %s_timeout got pc=%h exp=%h", name, instr_pc, 16'(pc)); end
    endtask

    task automatic test_stall();
        run_to_pc(5, "stall_reach");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'd5 || instr !== 16'h1005) begin
                failures++; $display("FAIL stall_hold%0d got v=%0h pc=%h i=%h exp v=1 pc=0005 i=1005", i, instr_valid, instr_pc, instr); end
        end
        stall = 0;
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_bubble got=%0h exp=0", instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'd6 || instr !== 16'h1006) begin
            failures++; $display("FAIL stall_next got v=%0h pc=%h i=%h exp v=1 pc=0006 i=1006", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_branch(input logic [15:0] tgt, input int exp_pc);
        branch_taken = 1; branch_target = tgt;
        step();
        branch_taken = 0; branch_target = $urandom;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL br_b0 got=%0h exp=0", instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL br_b1 got=%0h exp=0", instr_valid); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'(exp_pc + i) || instr !== 16'(16'h1000 + exp_pc + i)) begin
                failures++; $display("FAIL br_tgt%0d got v=%0h pc=%h i=%h exp pc=%h", i, instr_valid, instr_pc, instr, 16'(exp_pc + i)); end
        end
    endtask

    task automatic test_branch_in_hold();
        run_to_pc(7, "bh_reach");
        stall = 1;
        step();
        branch_taken = 1; branch_target = 16'h000A;
        step();
        branch_taken = 0; stall = 0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bh_drop got=%0h exp=0", instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bh_bubble got=%0h exp=0", instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'd10 || instr !== 16'h100A) begin
            failures++; $display("FAIL bh_target got v=%0h pc=%h i=%h exp v=1 pc=000a i=100a", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_reset_in_hold();
        run_to_pc(3, "rh_reach");
        stall = 1;
        step(); step();
        reset = 1;
        step();
        reset = 0; stall = 0;
        checks++; if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0 || imem_address !== 16'(RST_PC)) begin
            failures++; $display("FAIL rh_reset got v=%0h i=%h pc=%h a=%h exp all zero", instr_valid, instr, instr_pc, imem_address); end
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rh_fill got=%0h exp=0", instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0 || instr !== 16'h1000) begin
            failures++; $display("FAIL rh_restart got v=%0h pc=%h i=%h exp v=1 pc=0000 i=1000", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(99) < 2);
            branch_taken  = ($urandom_range(99) < 8);
            stall         = ($urandom_range(99) < 35);
            branch_target = 16'($urandom);
            step();
            checks++; if (instr_valid !== m_valid) begin
                failures++; $display("FAIL rnd_valid c=%0d got=%0h exp=%0h", c, instr_valid, m_valid); end
            if (m_valid) begin
                checks++; if (instr_pc !== 16'(m_pc) || instr !== m_instr) begin
                    failures++; $display("FAIL rnd_data c=%0d got pc=%h i=%h exp pc=%h i=%h", c, instr_pc, instr, 16'(m_pc), m_instr); end
            end
        end
        reset = 0; branch_taken = 0; stall = 0;
    endtask

    initial begin
        clk = 0; checks = 0; failures = 0;
        reset = 1; stall = 0; branch_taken = 0; branch_target = '0;
        m_valid = 0; m_pc = 0; m_instr = '0; m_next = 0; m_wait = 0; m_stalled = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'(16'h1000 + i);
        test_reset();
        test_startup();
        test_wrap();
        test_stall();
        test_branch(16'h0014, 20);
        test_branch(16'h0045, 5);
        test_branch_in_hold();
        test_reset_in_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch unit driving the synchronous-read instruction memory: owns the program counter, presents word addresses to the memory, absorbs its one-cycle registered read latency, and hands each instruction with its PC to decode over a valid/stall handshake. It handles sequential flow, decode back-pressure, branch redirects and wrap-around of the 32-word program space.

## Interface
- IMEM_DEPTH, 32, instruction memory depth in words; power of two.
- RESET_PC, 0, first fetch address after reset; must be below IMEM_DEPTH.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- stall  input  1  decode cannot accept `instr` this cycle.
- branch_taken  input  1  redirect fetch to `branch_target` this edge.
- branch_target  input  16  word address of the redirect.
- imem_address  output  16  word address to instruction memory; driven directly from the `fetch_pc` register.
- imem_instruction  input  16  memory read data; the word at the address sampled on the previous edge.
- instr  output  16  instruction to decode.
- instr_pc  output  16  word address of `instr`.
- instr_valid  output  1  `instr` and `instr_pc` are meaningful.

## Operation
- Registers: `fetch_pc`, `req_pc`, `instr`, `instr_pc`, `instr_valid`, and a 2-bit state (FILL, RUN, HOLD).
- PC width is log2(IMEM_DEPTH) bits, zero-extended to 16 on outputs.
- Increment wraps modulo IMEM_DEPTH: 31 -> 0.
- `branch_target` is masked to its low log2(IMEM_DEPTH) bits.
- Transfer: an instruction is consumed at an edge where `instr_valid`=1 and `stall`=0.
- Edge priority: reset > branch_taken > stall > normal flow.
- reset:
  - `fetch_pc`<=RESET_PC; `instr`, `instr_pc`, `instr_valid` <= 0; state <= FILL.
  - After reset, `imem_address` = RESET_PC.
- branch_taken, in any state:
  - `fetch_pc`<=masked target; `instr_valid`<=0 (the held or in-flight instruction is squashed); state <= FILL.
- FILL (no valid response is due):
  - `req_pc`<=`fetch_pc`; `fetch_pc`<=`fetch_pc`+1; state <= RUN.
- RUN with `stall`=0 or `instr_valid`=0:
  - `instr`<=`imem_instruction`; `instr_pc`<=`req_pc`; `instr_valid`<=1.
  - `req_pc`<=`fetch_pc`; `fetch_pc`<=`fetch_pc`+1.
- RUN with `stall`=1 and `instr_valid`=1:
  - Outputs hold; the in-flight response is discarded.
  - `fetch_pc`<=`instr_pc`+1; state <= HOLD.
- HOLD with `stall`=1: everything holds.
- HOLD with `stall`=0:
  - Decode consumes `instr` at this edge.
  - `instr_valid`<=0; `req_pc`<=`fetch_pc`; `fetch_pc`<=`fetch_pc`+1; state <= RUN.
- Memory reads are idempotent, so discarded responses are simply re-fetched; no skid buffer.

## Timing
- Reset values: `instr`=0, `instr_pc`=0, `instr_valid`=0, `imem_address`=RESET_PC; state FILL.
- Start-up: first edge with reset=0 is FILL->RUN. The second edge presents `instr`=mem[RESET_PC], valid.
- Steady state: one instruction per cycle, consecutive PCs.
- Branch sampled at edge B:
  - `instr_valid`=0 after edges B and B+1.
  - Target instruction is valid after edge B+2, a 2-cycle penalty.
- Stall release: one bubble cycle (`instr_valid`=0), then `instr_pc`+1 follows. No instruction is lost or duplicated.
- Stall while `instr_valid`=0: no effect.
- Branch during HOLD: the held instruction is dropped, not delivered.
- Reset mid-operation, in any state: outputs reach reset values after that edge.

## Structure
- Shared `risc_pkg` holds:
  - `IMEM_DEPTH` and `RESET_PC` defaults;
  - the `INSTR_W`=16 and `ADDR_W`=16 constants;
  - the fetch state encoding (FILL, RUN, HOLD), reused by the hazard unit.
- Single module, no sub-modules: the PC incrementer and mask are one line each.

## Test plan
- Reset then release, mem[i]=16'h1000+i -> `instr_valid` rises at the 2nd edge with pc 0 / 16'h1000, then pc 1, 2, 3 on consecutive cycles.
- Free-run past the end -> pc 31 / 16'h101F followed by pc 0 / 16'h1000.
- `stall` high 3 cycles while `instr_pc`=5 -> pc 5 held for 3 cycles, one `instr_valid`=0 cycle, then pc 6 / 16'h1006.
- Branches:
  - `branch_taken` with target 16'h0014 while running -> two invalid cycles, then pc 20 / 16'h1014, 21, ...
  - target 16'h0045 -> pc 5.
- Branch to 16'h000A asserted during HOLD at pc 7 -> pc 7 never transferred; pc 10 valid two edges later.
- Reset asserted in HOLD -> after the edge, `instr_valid`=0, `instr`=0, `instr_pc`=0, `imem_address`=RESET_PC; restart as in the first scenario.
